switch_control_vc_buffer: RTL
=============================

# switch_control_vc_buffer

Buffered, VC-aware front end for the switch controller. It takes per-input route reservation requests and relieves from the header/flit buffers, steers them onto the currently selected VC plane, and holds each request in a per-(VC, input) slot until the switch controller grants it. It also tracks the reservation until it is relieved. Holding requests lets VC-plane switching proceed without dropping them, and gives the buffers a ready-based backpressure path.

## Interface
- VC, 4: number of virtual-channel planes.
- INPUTS, 4: router input ports.
- OUTPUTS, 4: router output ports; REQUEST_WIDTH must be at least clog2(OUTPUTS).
- REQUEST_WIDTH, 2: width of one route request (output port index).
- SELECTOR_MODE, 0: 0 = VCPlaneSelector is a binary index; 1 = one-hot.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- VCPlaneSelector  input  VC+1  active VC plane.
- routeReserveRequestValid  input  INPUTS  per-input request strobe.
- routeReserveRequest  input  INPUTS*REQUEST_WIDTH  requested output per input.
- routeRelieve  input  INPUTS  per-input relieve strobe.
- routeReserveRequestReady  output  INPUTS  slot (selected VC, input) can accept a request.
- routeReserveRequestValidVC  output  VC*INPUTS  slot holds an ungranted request.
- routeReserveRequestVC  output  VC*INPUTS*REQUEST_WIDTH  held request per slot.
- routeReserveGrantVC  input  VC*INPUTS  grant from the switch controller, per slot.
- routeRelieveVC  output  VC*INPUTS  one-cycle relieve pulse per slot.
- selectorError  output  1  VCPlaneSelector is invalid (combinational).
- relieveError  output  1  sticky: a relieve arrived at a slot that was not RESERVED.

## Operation
- Slot index is s = v*INPUTS + i. Each slot runs a 3-state FSM: IDLE, PENDING, RESERVED.
- Selector decode:
  - Binary mode: valid if VCPlaneSelector < VC.
  - One-hot mode: valid if exactly one of bits [VC-1:0] is set and bit VC is clear.
  - When invalid, selectorError=1, all ready=0, and no capture or relieve is applied.
- routeReserveRequestReady[i] = selector valid AND slot(sel, i) is IDLE.
- IDLE -> PENDING: when valid[i] and ready[i] are both high. The slot latches routeReserveRequest[i].
- PENDING -> RESERVED: on routeReserveGrantVC[s]. A grant in any other state is ignored.
- RESERVED -> IDLE: on routeRelieve[i] while slot(sel, i) is selected. routeRelieveVC[s] pulses for exactly one cycle.
- Relieve to a selected slot that is IDLE or PENDING: the slot state is unchanged, no pulse is produced, and relieveError is set. relieveError clears only on reset.
- routeReserveRequestValidVC[s] = (state == PENDING), registered.
- routeReserveRequestVC slice:
  - holds the captured value in PENDING and RESERVED;
  - is 0 in IDLE, cleared on entry.
- Unselected VC planes keep their state. Only the selected plane reacts to valid and relieve strobes. Grants act on any plane.

## Timing
- Reset: every slot goes IDLE. All outputs are 0: ValidVC, RequestVC, RelieveVC and relieveError. Ready still follows its combinational equation. Reset asserted mid-transaction discards pending and reserved slots with no relieve pulse.
- Request accepted at edge N -> ValidVC[s] high after edge N (cycle N+1).
- Grant sampled at edge N -> ValidVC[s] low from cycle N+1.
- Earliest re-request on the same slot is one cycle after the relieve edge.
- Relieve sampled at edge N -> RelieveVC[s] high for cycle N+1 only.
- Grant and relieve arriving together on a PENDING slot: the grant is applied and relieveError is set.
- Selector changing between cycles: this is legal. Behaviour follows the selector value sampled at each edge.

## Structure
- Shared package holds:
  - the slot state encoding (IDLE=0, PENDING=1, RESERVED=2);
  - the selector-mode constants;
  - a selector decode function returning the plane index and a valid flag.
- Sub-module vc_route_slot holds one slot's FSM, request register and relieve pulse. The top instantiates it VC*INPUTS times with generate, and does the selector decode and error logic.

## Test plan
- Reset values: hold rst=0, then release. Expect all outputs 0 and ready=4'hF with selector=0.
- Capture, grant, relieve: selector=2, valid[1]=1, request[1]=3.
  - Expect ValidVC[9]=1 and RequestVC slot 9 = 3 one cycle later.
  - Grant[9] -> ValidVC[9]=0.
  - Relieve[1] -> RelieveVC[9] high for one cycle, then ready[1]=1.
- Plane isolation: request on plane 0, input 0, then switch to selector=1. Expect slot 0 still PENDING, ready[0]=1 for plane 1, and a second capture into slot 4.
- Backpressure: a second valid[0] to a PENDING slot -> ready[0]=0, no capture, RequestVC unchanged.
- Bad selector:
  - Binary mode with selector=5 -> selectorError=1, ready=0, no state change.
  - One-hot mode with 5'b00011 -> same response.
- Relieve error and mid-operation reset: relieve to an IDLE slot -> relieveError=1 and no pulse. Asserting rst while slots are PENDING clears everything asynchronously.

Source files
------------

// File: rtl/switch_control_vc_buffer_pkg.sv
// Shared types and helpers for the VC-aware switch-control front end:
// slot state encoding, selector modes and the plane-selector decoder.
package switch_control_vc_buffer_pkg;

  // Widest selector the decoder handles (VC planes up to MAX_VC - 1).
  localparam int MAX_VC = 31;
  localparam int PLANE_W = 5;

  localparam int SEL_MODE_BINARY = 0;
  localparam int SEL_MODE_ONEHOT = 1;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_PENDING  = 2'd1,
    SLOT_RESERVED = 2'd2
  } slotState_e;

  typedef struct packed {
    logic               valid;
    logic [PLANE_W-1:0] plane;
  } selDecode_t;

  // Decodes a zero-extended selector into a plane index plus validity flag.
  function automatic selDecode_t decodeSelector(input logic [MAX_VC:0] sel,
                                                input int vcCount,
                                                input int mode);
    selDecode_t res;
    int ones;
    logic [MAX_VC:0] limit;
    res.valid = 1'b0;
    res.plane = '0;
    ones = 0;
    limit = 32'(vcCount);
    if (mode == SEL_MODE_ONEHOT) begin
      for (int k = 0; k <= MAX_VC; k++) begin
        if ((k < vcCount) && sel[k]) begin
          ones++;
          res.plane = k[PLANE_W-1:0];
        end else begin
          ones = ones;
        end
      end
      // The bit just above the plane field must be clear in one-hot mode.
      res.valid = (ones == 1) && !sel[vcCount];
    end else begin
      res.valid = (sel < limit);
      res.plane = sel[PLANE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/switch_control_vc_buffer_vc_route_slot.sv
// One (VC, input) slot: IDLE -> PENDING -> RESERVED -> IDLE lifecycle,
// the held route request and the one-cycle relieve pulse.
module vc_route_slot
  import switch_control_vc_buffer_pkg::*;
#(
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [REQUEST_WIDTH-1:0] requestIn,
  input  logic                     grant,
  input  logic                     relieve,
  output logic                     idle,
  output logic                     validOut,
  output logic [REQUEST_WIDTH-1:0] requestOut,
  output logic                     relievePulse,
  output logic                     relieveErr
);

  slotState_e               state_r, stateNext_s;
  logic [REQUEST_WIDTH-1:0] request_r, requestNext_s;
  logic                     pulse_r, pulseNext_s;
  logic                     valid_r;

  // Slot state, held request, pending flag and relieve pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= SLOT_IDLE;
      request_r <= '0;
      pulse_r   <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      request_r <= requestNext_s;
      pulse_r   <= pulseNext_s;
      valid_r   <= (stateNext_s == SLOT_PENDING);
    end
  end

  // Next-state logic; a relieve on a non-reserved slot only flags an error.
  always_comb begin
    stateNext_s   = state_r;
    requestNext_s = request_r;
    pulseNext_s   = 1'b0;
    relieveErr    = 1'b0;
    case (state_r)
      SLOT_IDLE: begin
        if (capture) begin
          stateNext_s   = SLOT_PENDING;
          requestNext_s = requestIn;
        end else begin
          stateNext_s = SLOT_IDLE;
        end
        relieveErr = relieve;
      end
      SLOT_PENDING: begin
        if (grant) begin
          stateNext_s = SLOT_RESERVED;
        end else begin
          stateNext_s = SLOT_PENDING;
        end
        relieveErr = relieve;
      end
      SLOT_RESERVED: begin
        if (relieve) begin
          stateNext_s   = SLOT_IDLE;
          requestNext_s = '0;
          pulseNext_s   = 1'b1;
        end else begin
          stateNext_s = SLOT_RESERVED;
        end
      end
      default: begin
        stateNext_s   = SLOT_IDLE;
        requestNext_s = '0;
      end
    endcase
  end

  assign idle         = (state_r == SLOT_IDLE);
  assign validOut     = valid_r;
  assign requestOut   = request_r;
  assign relievePulse = pulse_r;

endmodule

// File: rtl/switch_control_vc_buffer.sv
// VC-aware buffered front end: steers per-input requests and relieves onto
// the selected VC plane and holds them in per-(VC, input) slots until granted.
module switch_control_vc_buffer
  import switch_control_vc_buffer_pkg::*;
#(
  parameter int VC            = 4,
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2,
  parameter int SELECTOR_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VC:0]                         VCPlaneSelector,
  input  logic [INPUTS-1:0]                   routeReserveRequestValid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0]     routeReserveRequest,
  input  logic [INPUTS-1:0]                   routeRelieve,
  output logic [INPUTS-1:0]                   routeReserveRequestReady,
  output logic [VC*INPUTS-1:0]                routeReserveRequestValidVC,
  output logic [VC*INPUTS*REQUEST_WIDTH-1:0]  routeReserveRequestVC,
  input  logic [VC*INPUTS-1:0]                routeReserveGrantVC,
  output logic [VC*INPUTS-1:0]                routeRelieveVC,
  output logic                                selectorError,
  output logic                                relieveError
);

  localparam int SLOTS = VC * INPUTS;

  if (REQUEST_WIDTH < $clog2(OUTPUTS)) begin : gBadWidth
    $error("REQUEST_WIDTH too narrow for OUTPUTS");
  end

  logic [MAX_VC:0]    selExt_s;
  selDecode_t         decoded_s;
  logic [VC-1:0]      planeSel_s;
  logic [SLOTS-1:0]   slotIdle_s;
  logic [SLOTS-1:0]   slotRelieveErr_s;
  logic [INPUTS-1:0]  ready_s;
  logic               relieveError_r;

  assign selExt_s      = {{(MAX_VC - VC){1'b0}}, VCPlaneSelector};
  assign decoded_s     = decodeSelector(selExt_s, VC, SELECTOR_MODE);
  assign selectorError = !decoded_s.valid;

  for (genvar v = 0; v < VC; v++) begin : gPlane
    assign planeSel_s[v] = decoded_s.valid && (decoded_s.plane == PLANE_W'(v));
    for (genvar i = 0; i < INPUTS; i++) begin : gInput
      localparam int S = v * INPUTS + i;
      vc_route_slot #(.REQUEST_WIDTH(REQUEST_WIDTH)) uSlot (
        .clk          (clk),
        .rst          (rst),
        .capture      (planeSel_s[v] && routeReserveRequestValid[i] && slotIdle_s[S]),
        .requestIn    (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]),
        .grant        (routeReserveGrantVC[S]),
        .relieve      (planeSel_s[v] && routeRelieve[i]),
        .idle         (slotIdle_s[S]),
        .validOut     (routeReserveRequestValidVC[S]),
        .requestOut   (routeReserveRequestVC[S*REQUEST_WIDTH +: REQUEST_WIDTH]),
        .relievePulse (routeRelieveVC[S]),
        .relieveErr   (slotRelieveErr_s[S])
      );
    end
  end

  // Ready per input: the selected plane's slot for that input is idle.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < INPUTS; i++) begin
      for (int v = 0; v < VC; v++) begin
        ready_s[i] = ready_s[i] | (planeSel_s[v] & slotIdle_s[v*INPUTS+i]);
      end
    end
  end

  assign routeReserveRequestReady = ready_s;

  // Sticky relieve-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relieveError_r <= 1'b0;
    end else if (|slotRelieveErr_s) begin
      relieveError_r <= 1'b1;
    end else begin
      relieveError_r <= relieveError_r;
    end
  end

  assign relieveError = relieveError_r;

endmodule
